// File: rtl/intc_pkg.sv
// Shared types and constants for the N-channel vectored interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Control register offsets relative to CTRL_OFS
    localparam int unsigned ENABLE_OFS  = 0;
    localparam int unsigned PENDING_OFS = 4;
    localparam int unsigned ACTIVE_OFS  = 8;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Width of a source index; never narrower than one bit
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module intc_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // First set bit from index 0 upward claims the grant
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/intc_prio_n.sv
// N-channel vectored interrupt controller: edge-latched pending bits,
// priority grant, IRQ/IACK handshake and a memory-mapped register window.
module intc_prio_n
    import intc_pkg::*;
#(
    parameter int unsigned   N_IRQ      = 4,
    parameter int unsigned   AW         = 32,
    parameter logic [AW-1:0] BASE_ADDR  = 'h00020000,
    parameter logic [AW-1:0] ISR_STRIDE = 'h20,
    parameter logic [AW-1:0] CTRL_OFS   = 'h1000,
    parameter logic [AW-1:0] WIN_SIZE   = 'h2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IRQ-1:0]         done,
    input  logic                     iack,
    input  logic [AW-1:0]            input_addr,
    input  logic                     write_enable,
    input  logic [AW-1:0]            write_data,
    output logic [AW-1:0]            read_data,
    output logic                     irq,
    output logic [AW-1:0]            isr_addr,
    output logic [id_w(N_IRQ)-1:0]   irq_id,
    output logic                     error
);

    localparam int unsigned IW = id_w(N_IRQ);

    state_t           state;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] done_q;
    logic             armed;
    logic [AW-1:0]    isr_tab [N_IRQ];

    logic [AW-1:0]    ofs;
    logic             in_win, wr;
    logic             hit_enable, hit_pending, hit_active, isr_hit, mapped;
    logic [IW-1:0]    isr_sel;
    logic [N_IRQ-1:0] pend_set, pend_w1c, ack_clr;
    logic             cand_valid;
    logic [IW-1:0]    winner;

    assign ofs         = input_addr - BASE_ADDR;
    assign in_win      = (input_addr >= BASE_ADDR) && (ofs < WIN_SIZE);
    assign wr          = write_enable && in_win;
    assign hit_enable  = in_win && (ofs == CTRL_OFS + AW'(ENABLE_OFS));
    assign hit_pending = in_win && (ofs == CTRL_OFS + AW'(PENDING_OFS));
    assign hit_active  = in_win && (ofs == CTRL_OFS + AW'(ACTIVE_OFS));
    assign mapped      = isr_hit || hit_enable || hit_pending || hit_active;

    // ISR table entry decode: exact match on entry i at i*ISR_STRIDE
    always_comb begin
        isr_hit = 1'b0;
        isr_sel = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (in_win && (ofs == AW'(i) * ISR_STRIDE)) begin
                isr_hit = 1'b1;
                isr_sel = IW'(i);
            end
        end
    end

    // Combinational register read; unmapped addresses return zero
    always_comb begin
        read_data = '0;
        if (isr_hit)          read_data = isr_tab[isr_sel];
        else if (hit_enable)  read_data = AW'(enable);
        else if (hit_pending) read_data = AW'(pending);
        else if (hit_active)  read_data = AW'({state != IDLE, irq_id});
    end

    // The first edge after reset only primes done_q, so a done level held
    // across reset release is not mistaken for a new rising edge.
    assign pend_set = done & ~done_q & {N_IRQ{armed}};
    assign pend_w1c = (wr && hit_pending) ? write_data[N_IRQ-1:0] : '0;
    assign ack_clr  = (state == ASSERT && iack) ? (N_IRQ'(1) << irq_id) : '0;

    intc_prio_enc #(.N(N_IRQ), .IW(IW)) u_enc (
        .req   (pending & enable),
        .valid (cand_valid),
        .idx   (winner)
    );

    // Edge detector history and post-reset arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
            armed  <= 1'b0;
        end else begin
            done_q <= done;
            armed  <= 1'b1;
        end
    end

    // Pending bits: clears from ACK entry or W1C, a same-cycle set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~(pend_w1c | ack_clr)) | pend_set;
    end

    // ENABLE and ISR table writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= '1;
            for (int unsigned i = 0; i < N_IRQ; i++) isr_tab[i] <= '0;
        end else if (wr) begin
            if (hit_enable) enable <= write_data[N_IRQ-1:0];
            if (isr_hit)    isr_tab[isr_sel] <= write_data;
        end
    end

    // Sticky fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) error <= 1'b0;
        else if ((wr && (!mapped || hit_active)) || (state == IDLE && iack))
            error <= 1'b1;
    end

    // Grant/acknowledge FSM with registered irq, irq_id and isr_addr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            irq      <= 1'b0;
            irq_id   <= '0;
            isr_addr <= '0;
        end else begin
            case (state)
                IDLE: if (cand_valid) begin
                    state    <= ASSERT;
                    irq      <= 1'b1;
                    irq_id   <= winner;
                    isr_addr <= isr_tab[winner];
                end
                ASSERT: if (iack) begin
                    state <= ACK;
                    irq   <= 1'b0;
                end
                ACK: if (!iack) state <= IDLE;
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc_prio_n.sv
// Directed self-checking bench for intc_prio_n, plus N_IRQ=1/32 sweep instances.
module tb_intc_prio_n;

    localparam logic [31:0] BASE = 32'h00020000;
    localparam logic [31:0] ENA  = 32'h00021000;
    localparam logic [31:0] PEND = 32'h00021004;
    localparam logic [31:0] ACTV = 32'h00021008;

    int vectors = 0;
    int miscompares = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  done = '0;
    logic        iack = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] isr_addr;
    logic [1:0]  irq_id;
    logic        error;

    // Sweep instances share a second bus
    logic        s_iack = 1'b0;
    logic [31:0] s_addr = '0;
    logic        s_we = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [0:0]  d1 = '0;
    logic [31:0] d32 = '0;
    logic [31:0] rd1, rd32, isr1, isr32;
    logic        irq1, irq32, err1, err32;
    logic [0:0]  id1;
    logic [4:0]  id32;

    always #5 clk = ~clk;

    intc_prio_n #(.N_IRQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .iack(iack),
        .input_addr(addr), .write_enable(we), .write_data(wdata),
        .read_data(rdata), .irq(irq), .isr_addr(isr_addr),
        .irq_id(irq_id), .error(error)
    );

    intc_prio_n #(.N_IRQ(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .done(d1), .iack(s_iack),
        .input_addr(s_addr), .write_enable(s_we), .write_data(s_wdata),
        .read_data(rd1), .irq(irq1), .isr_addr(isr1),
        .irq_id(id1), .error(err1)
    );

    intc_prio_n #(.N_IRQ(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .done(d32), .iack(s_iack),
        .input_addr(s_addr), .write_enable(s_we), .write_data(s_wdata),
        .read_data(rd32), .irq(irq32), .isr_addr(isr32),
        .irq_id(id32), .error(err32)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic s_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr = a; s_wdata = d; s_we = 1'b1;
        @(negedge clk);
        s_we = 1'b0;
    endtask

    task automatic iack_pulse();
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        apply_reset();
        vectors++;
        if (irq !== 1'b0 || irq_id !== 2'd0 || isr_addr !== 32'h0 || error !== 1'b0) begin
            $display("FAIL reset_outputs: got irq=%b id=%0d isr=%h err=%b want 0 0 0 0", irq, irq_id, isr_addr, error);
            miscompares++;
        end
        bus_read(ENA, r);
        vectors++;
        if (r !== 32'hF) begin $display("FAIL reset_enable: got %h want 0000000f", r); miscompares++; end
        bus_read(PEND, r);
        vectors++;
        if (r !== 32'h0) begin $display("FAIL reset_pending: got %h want 00000000", r); miscompares++; end
        bus_read(ACTV, r);
        vectors++;
        if (r !== 32'h0) begin $display("FAIL reset_active: got %h want 00000000", r); miscompares++; end
    endtask

    task automatic test_isr_table();
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) bus_write(BASE + i * 32'h20, 32'h0A + i);
        for (int unsigned i = 0; i < 4; i++) begin
            bus_read(BASE + i * 32'h20, r);
            vectors++;
            if (r !== 32'h0A + i) begin
                $display("FAIL isr_readback[%0d]: got %h want %h", i, r, 32'h0A + i);
                miscompares++;
            end
        end
        vectors++;
        if (error !== 1'b0) begin $display("FAIL isr_write_error: got %b want 0", error); miscompares++; end
    endtask

    task automatic test_single();
        logic [31:0] r;
        done[3] = 1'b1;
        @(negedge clk);
        done[3] = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin $display("FAIL single_latency: irq got %b want 0 one edge after", irq); miscompares++; end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1 || isr_addr !== 32'h0D || irq_id !== 2'd3) begin
            $display("FAIL single_grant: got irq=%b isr=%h id=%0d want 1 0000000d 3", irq, isr_addr, irq_id);
            miscompares++;
        end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        bus_read(PEND, r);
        vectors++;
        if (irq !== 1'b0 || r !== 32'h0) begin
            $display("FAIL single_ack: got irq=%b pending=%h want 0 00000000", irq, r);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_priority_back_to_back();
        done = 4'b0101;
        @(negedge clk);
        done = 4'b0000;
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1 || irq_id !== 2'd0 || isr_addr !== 32'h0A) begin
            $display("FAIL prio_first: got irq=%b id=%0d isr=%h want 1 0 0000000a", irq, irq_id, isr_addr);
            miscompares++;
        end
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin $display("FAIL b2b_gap_ack: irq got %b want 0", irq); miscompares++; end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin $display("FAIL b2b_gap_idle: irq got %b want 0", irq); miscompares++; end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1 || irq_id !== 2'd2 || isr_addr !== 32'h0C) begin
            $display("FAIL prio_second: got irq=%b id=%0d isr=%h want 1 2 0000000c", irq, irq_id, isr_addr);
            miscompares++;
        end
        iack_pulse();
    endtask

    task automatic test_enable_mask();
        logic [31:0] r;
        bus_write(ENA, 32'hB);
        done[2] = 1'b1;
        @(negedge clk);
        done[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_read(PEND, r);
        vectors++;
        if (irq !== 1'b0 || r !== 32'h4) begin
            $display("FAIL mask_hold: got irq=%b pending=%h want 0 00000004", irq, r);
            miscompares++;
        end
        bus_write(ENA, 32'hF);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1 || isr_addr !== 32'h0C) begin
            $display("FAIL mask_release: got irq=%b isr=%h want 1 0000000c", irq, isr_addr);
            miscompares++;
        end
        bus_read(ACTV, r);
        vectors++;
        if (r !== 32'h6) begin $display("FAIL active_read: got %h want 00000006", r); miscompares++; end
        iack_pulse();
    endtask

    task automatic test_error();
        logic [31:0] r;
        iack_pulse();
        vectors++;
        if (error !== 1'b1) begin $display("FAIL err_iack_idle: got %b want 1", error); miscompares++; end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (error !== 1'b1) begin $display("FAIL err_sticky: got %b want 1", error); miscompares++; end
        apply_reset();
        bus_write(32'h00050000, 32'h1);
        vectors++;
        if (error !== 1'b0) begin $display("FAIL err_outside_window: got %b want 0", error); miscompares++; end
        bus_write(32'h00020010, 32'h1);
        vectors++;
        if (error !== 1'b1) begin $display("FAIL err_unmapped: got %b want 1", error); miscompares++; end
        bus_read(32'h00020010, r);
        vectors++;
        if (r !== 32'h0) begin $display("FAIL unmapped_read: got %h want 00000000", r); miscompares++; end
        apply_reset();
        bus_write(ACTV, 32'h1);
        vectors++;
        if (error !== 1'b1) begin $display("FAIL err_active_write: got %b want 1", error); miscompares++; end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        apply_reset();
        bus_write(BASE + 32'h20, 32'h0B);
        done[1] = 1'b1;
        @(negedge clk);
        done[1] = 1'b0;
        @(negedge clk);
        bus_read(PEND, r);
        vectors++;
        if (irq !== 1'b1 || isr_addr !== 32'h0B || r !== 32'h2) begin
            $display("FAIL pre_reset_grant: got irq=%b isr=%h pending=%h want 1 0000000b 00000002", irq, isr_addr, r);
            miscompares++;
        end
        #1;
        rst_n = 1'b0;
        done[1] = 1'b1;
        #1;
        vectors++;
        if (irq !== 1'b0 || isr_addr !== 32'h0 || rdata !== 32'h0) begin
            $display("FAIL async_reset: got irq=%b isr=%h pending=%h want 0 00000000 00000000", irq, isr_addr, rdata);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(PEND, r);
        vectors++;
        if (irq !== 1'b0 || r !== 32'h0) begin
            $display("FAIL held_done_release: got irq=%b pending=%h want 0 00000000", irq, r);
            miscompares++;
        end
        done[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        bit seen;
        for (int unsigned i = 0; i < 32; i++) s_write(BASE + i * 32'h20, 32'h100 + i);
        for (int unsigned i = 0; i < 32; i++) begin
            d32[i] = 1'b1;
            @(negedge clk);
            d32 = '0;
            seen = 1'b0;
            for (int unsigned k = 0; k < 6 && !seen; k++) begin
                if (irq32) seen = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!seen || id32 !== 5'(i) || isr32 !== 32'h100 + i) begin
                $display("FAIL sweep32[%0d]: got irq=%b id=%0d isr=%h want 1 %0d %h", i, irq32, id32, isr32, i, 32'h100 + i);
                miscompares++;
            end
            s_iack = 1'b1;
            @(negedge clk);
            s_iack = 1'b0;
            @(negedge clk);
        end
        d1 = 1'b1;
        @(negedge clk);
        d1 = 1'b0;
        seen = 1'b0;
        for (int unsigned k = 0; k < 6 && !seen; k++) begin
            if (irq1) seen = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!seen || id1 !== 1'b0 || isr1 !== 32'h100) begin
            $display("FAIL sweep1: got irq=%b id=%0d isr=%h want 1 0 00000100", irq1, id1, isr1);
            miscompares++;
        end
        s_iack = 1'b1;
        @(negedge clk);
        s_iack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_isr_table();
        test_single();
        test_priority_back_to_back();
        test_enable_mask();
        test_error();
        test_async_reset();
        apply_reset();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
